// File: rtl/vec_pkg.sv
// Shared constants and state type for the vector operand loader.
package vec_pkg;

    localparam int N_ELEM         = 5;   // elements per vector
    localparam int N_WORDS        = 10;  // A and B together
    localparam int IDX_W          = 4;   // wide enough to index N_WORDS
    localparam int DEFAULT_STRIDE = 4;   // byte step between elements

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAST  = 2'd2,
        VALID = 2'd3
    } vec_state_e;

endpackage

// File: rtl/vector_operand_bank.sv
// Ten-entry operand register file: entries 0..4 are A, 5..9 are B.
module vector_operand_bank
    import vec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] a_0,
    output logic [DATA_W-1:0] a_1,
    output logic [DATA_W-1:0] a_2,
    output logic [DATA_W-1:0] a_3,
    output logic [DATA_W-1:0] a_4,
    output logic [DATA_W-1:0] b_0,
    output logic [DATA_W-1:0] b_1,
    output logic [DATA_W-1:0] b_2,
    output logic [DATA_W-1:0] b_3,
    output logic [DATA_W-1:0] b_4
);

    logic [DATA_W-1:0] regs [N_WORDS];

    // Write one entry per cycle; reset clears the whole file asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_WORDS; k++) begin
                regs[k] <= '0;
            end
        end else if (we && (widx < IDX_W'(N_WORDS))) begin
            regs[widx] <= wdata;
        end
    end

    assign a_0 = regs[0];
    assign a_1 = regs[1];
    assign a_2 = regs[2];
    assign a_3 = regs[3];
    assign a_4 = regs[4];
    assign b_0 = regs[5];
    assign b_1 = regs[6];
    assign b_2 = regs[7];
    assign b_3 = regs[8];
    assign b_4 = regs[9];

endmodule

// File: rtl/vector_operand_loader.sv
// Fetches vectors A and B (5 words each) from a 1-cycle-latency read port
// and presents them, with the latched ALU op, to the vector ALU.
//
// Handshake: vec_valid is high only in VALID and the operands are stable
// while it is high. A transfer happens on the rising edge where vec_valid
// and vec_ready are both 1; the loader is back in IDLE the next cycle.
// vec_ready outside VALID has no effect.
module vector_operand_loader
    import vec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OP_W   = 3,
    parameter int STRIDE = DEFAULT_STRIDE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [OP_W-1:0]   op,
    output logic              busy,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] a_0,
    output logic [DATA_W-1:0] a_1,
    output logic [DATA_W-1:0] a_2,
    output logic [DATA_W-1:0] a_3,
    output logic [DATA_W-1:0] a_4,
    output logic [DATA_W-1:0] b_0,
    output logic [DATA_W-1:0] b_1,
    output logic [DATA_W-1:0] b_2,
    output logic [DATA_W-1:0] b_3,
    output logic [DATA_W-1:0] b_4,
    output logic [OP_W-1:0]   alu_op,
    output logic              vec_valid,
    input  logic              vec_ready,
    output vec_state_e        dbg_state
);

    vec_state_e        state_q, state_d;
    logic [IDX_W-1:0]  issue_q;     // index currently on the read port
    logic [IDX_W-1:0]  cap_idx_q;   // index whose data is on mem_rdata
    logic              cap_en_q;    // mem_rdata carries a requested word
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic              issue_last;
    logic [IDX_W-1:0]  issue_next;

    // Element address; indices 0..4 walk A, 5..9 walk B, modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] elem_addr(
        input logic [ADDR_W-1:0] ba,
        input logic [ADDR_W-1:0] bb,
        input logic [IDX_W-1:0]  idx
    );
        if (idx < IDX_W'(N_ELEM)) begin
            return ba + ADDR_W'(STRIDE) * ADDR_W'(idx);
        end
        return bb + ADDR_W'(STRIDE) * ADDR_W'(idx - IDX_W'(N_ELEM));
    endfunction

    assign issue_last = (issue_q == IDX_W'(N_WORDS - 1));
    assign issue_next = issue_q + IDX_W'(1);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)      state_d = FETCH;
            FETCH:   if (issue_last) state_d = LAST;
            LAST:                    state_d = VALID;
            VALID:   if (vec_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Request issue, operand latching and the capture pipeline stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_q   <= '0;
            cap_idx_q <= '0;
            cap_en_q  <= 1'b0;
            base_a_q  <= '0;
            base_b_q  <= '0;
            alu_op    <= '0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            // Data for the request issued this cycle arrives next cycle.
            cap_en_q  <= mem_re;
            cap_idx_q <= issue_q;
            if (state_q == IDLE && start) begin
                base_a_q <= base_a;
                base_b_q <= base_b;
                alu_op   <= op;
                issue_q  <= '0;
                mem_re   <= 1'b1;
                mem_addr <= base_a;
            end else if (state_q == FETCH) begin
                if (issue_last) begin
                    mem_re <= 1'b0;   // address holds its last value
                end else begin
                    issue_q  <= issue_next;
                    mem_addr <= elem_addr(base_a_q, base_b_q, issue_next);
                end
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign vec_valid = (state_q == VALID);
    assign dbg_state = state_q;

    vector_operand_bank #(
        .DATA_W (DATA_W)
    ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (cap_en_q),
        .widx    (cap_idx_q),
        .wdata   (mem_rdata),
        .a_0     (a_0),
        .a_1     (a_1),
        .a_2     (a_2),
        .a_3     (a_3),
        .a_4     (a_4),
        .b_0     (b_0),
        .b_1     (b_1),
        .b_2     (b_2),
        .b_3     (b_3),
        .b_4     (b_4)
    );

endmodule

// File: tb/tb_vector_operand_loader.sv
// Self-checking bench for vector_operand_loader.
module tb_vector_operand_loader;
    import vec_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] base_a;
    logic [31:0] base_b;
    logic [2:0]  op;
    logic        busy;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] a_0, a_1, a_2, a_3, a_4;
    logic [31:0] b_0, b_1, b_2, b_3, b_4;
    logic [2:0]  alu_op;
    logic        vec_valid;
    logic        vec_ready;
    vec_state_e  dbg_state;

    int errors = 0;
    int checks = 0;

    // Memory contents: word(addr) = (addr + mem_off) ^ mem_xor.
    logic [31:0] mem_off;
    logic [31:0] mem_xor;

    logic [31:0] exp_q [$];      // expected read addresses in issue order
    logic [31:0] exp_ops [10];   // operands the current load must produce
    logic [31:0] held_ops [10];  // operands the bank holds before this load
    logic [2:0]  exp_op;
    logic [31:0] ops [10];

    vector_operand_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_a    (base_a),
        .base_b    (base_b),
        .op        (op),
        .busy      (busy),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .a_0       (a_0),
        .a_1       (a_1),
        .a_2       (a_2),
        .a_3       (a_3),
        .a_4       (a_4),
        .b_0       (b_0),
        .b_1       (b_1),
        .b_2       (b_2),
        .b_3       (b_3),
        .b_4       (b_4),
        .alu_op    (alu_op),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr + mem_off) ^ mem_xor;
    endfunction

    // Synchronous read port, 1-cycle latency.
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_word(mem_addr);
    end

    always_comb begin
        ops[0] = a_0; ops[1] = a_1; ops[2] = a_2; ops[3] = a_3; ops[4] = a_4;
        ops[5] = b_0; ops[6] = b_1; ops[7] = b_2; ops[8] = b_3; ops[9] = b_4;
    end

    // ---------------- driver tasks ----------------
    // Runs one load from the start cycle (cycle 0) to the first VALID cycle
    // (cycle 12). Called #1 after a rising edge with the DUT idle.
    task automatic do_load(input logic [31:0] ba, input logic [31:0] bb,
                           input logic [2:0] o, input bit poke);
        logic [31:0] a;
        logic [31:0] last_b;
        exp_q.delete();
        for (int k = 0; k < 5; k++) exp_q.push_back(ba + 32'(4 * k));
        for (int k = 0; k < 5; k++) exp_q.push_back(bb + 32'(4 * k));
        for (int k = 0; k < 10; k++) exp_ops[k] = mem_word(exp_q[k]);
        last_b = bb + 32'd16;
        exp_op = o;

        base_a = ba; base_b = bb; op = o; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (poke && c == 5) begin
                start = 1'b1; base_a = 32'h900; base_b = 32'h980; op = ~o;
            end
            if (poke && c == 6) start = 1'b0;
            a = exp_q.pop_front();
            checks++;
            if (mem_re !== 1'b1 || mem_addr !== a) begin
                errors++;
                $display("FAIL issue c%0d: mem_re=%b addr=%h, expected re=1 addr=%h", c, mem_re, mem_addr, a);
            end
            checks++;
            if (busy !== 1'b1 || vec_valid !== 1'b0) begin
                errors++;
                $display("FAIL fetch_flags c%0d: busy=%b valid=%b, expected 1/0", c, busy, vec_valid);
            end
            if (c == 1) begin
                checks++;
                if (alu_op !== o) begin
                    errors++;
                    $display("FAIL alu_op_at_e0: got %0d expected %0d", alu_op, o);
                end
            end
            if (c <= 3) begin
                for (int k = 0; k < 10; k++) begin
                    checks++;
                    if (ops[k] !== ((c == 3 && k == 0) ? exp_ops[0] : held_ops[k])) begin
                        errors++;
                        $display("FAIL hold c%0d op%0d: got %h expected %h", c, k, ops[k],
                                 (c == 3 && k == 0) ? exp_ops[0] : held_ops[k]);
                    end
                end
            end
            @(posedge clk); #1;
        end
        // cycle 11
        checks++;
        if (mem_re !== 1'b0 || mem_addr !== last_b || vec_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL last_cycle: re=%b addr=%h valid=%b busy=%b, expected 0 %h 0 1",
                     mem_re, mem_addr, vec_valid, busy, last_b);
        end
        @(posedge clk); #1;
        // cycle 12
        checks++;
        if (vec_valid !== 1'b1 || busy !== 1'b1 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL valid_c12: valid=%b busy=%b re=%b, expected 1 1 0", vec_valid, busy, mem_re);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (ops[k] !== exp_ops[k]) begin
                errors++;
                $display("FAIL operand%0d: got %h expected %h", k, ops[k], exp_ops[k]);
            end
        end
        checks++;
        if (alu_op !== exp_op) begin
            errors++;
            $display("FAIL alu_op: got %0d expected %0d", alu_op, exp_op);
        end
        for (int k = 0; k < 10; k++) held_ops[k] = exp_ops[k];
    endtask

    // Holds off vec_ready for 'stall' cycles, then completes the handshake.
    // With poke set, start is also raised in the handshake cycle.
    task automatic handshake(input int stall, input bit poke);
        vec_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            checks++;
            if (vec_valid !== 1'b1 || busy !== 1'b1 || alu_op !== exp_op) begin
                errors++;
                $display("FAIL stall s%0d: valid=%b busy=%b alu_op=%0d", s, vec_valid, busy, alu_op);
            end
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (ops[k] !== exp_ops[k]) begin
                    errors++;
                    $display("FAIL stall_operand%0d: got %h expected %h", k, ops[k], exp_ops[k]);
                end
            end
        end
        vec_ready = 1'b1;
        if (poke) begin
            start = 1'b1; base_a = 32'h900;
        end
        @(posedge clk); #1;
        vec_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (vec_valid !== 1'b0 || busy !== 1'b0 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: valid=%b busy=%b re=%b, expected 0 0 0", vec_valid, busy, mem_re);
        end
        if (poke) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || mem_re !== 1'b0) begin
                errors++;
                $display("FAIL start_in_handshake: busy=%b re=%b, expected 0 0", busy, mem_re);
            end
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (ops[k] !== exp_ops[k]) begin
                errors++;
                $display("FAIL post_hs_operand%0d: got %h expected %h", k, ops[k], exp_ops[k]);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (busy !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 32'h0 || alu_op !== 3'd0 ||
            vec_valid !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL %s: busy=%b re=%b addr=%h alu_op=%0d valid=%b state=%0d, expected all 0",
                     name, busy, mem_re, mem_addr, alu_op, vec_valid, dbg_state);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (ops[k] !== 32'h0) begin
                errors++;
                $display("FAIL %s operand%0d: got %h expected 0", name, k, ops[k]);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        start = 1'b0; base_a = '0; base_b = '0; op = '0; vec_ready = 1'b0;
        mem_off = 32'h1000; mem_xor = 32'h0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 10; k++) held_ops[k] = '0;
        @(posedge clk); #1;
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_basic_load();
        mem_off = 32'h1000; mem_xor = 32'h0;
        do_load(32'h100, 32'h200, 3'd2, 1'b0);
        checks++;
        if (a_0 !== 32'h1100 || a_4 !== 32'h1110 || b_0 !== 32'h1200 || b_4 !== 32'h1210 || alu_op !== 3'd2) begin
            errors++;
            $display("FAIL basic_consts: a0=%h a4=%h b0=%h b4=%h op=%0d", a_0, a_4, b_0, b_4, alu_op);
        end
        handshake(0, 1'b0);
    endtask

    task automatic test_backpressure();
        mem_off = $urandom; mem_xor = $urandom;
        do_load($urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0);
        handshake(20, 1'b0);
    endtask

    task automatic test_ignored_start();
        mem_off = $urandom; mem_xor = $urandom;
        do_load(32'h300, 32'h700, 3'd5, 1'b1);
        handshake(2, 1'b1);
    endtask

    task automatic test_wrap();
        mem_off = 32'h55; mem_xor = 32'hA5A5_0000;
        do_load(32'hFFFF_FFF8, 32'hFFFF_FFFE, 3'd7, 1'b0);
        handshake(1, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        mem_off = $urandom; mem_xor = $urandom;
        base_a = 32'h500; base_b = 32'h600; op = 3'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        // cycle 6 of the load
        reset_n = 1'b0;
        #1 check_all_zero("reset_mid_load");
        for (int k = 0; k < 10; k++) held_ops[k] = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle_after_abort");
        do_load(32'h40, 32'($urandom), 3'd1, 1'b0);
        handshake(0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            mem_off = $urandom; mem_xor = $urandom;
            do_load($urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0);
            handshake($urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            mem_off = $urandom; mem_xor = $urandom;
            do_load($urandom, $urandom, 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
            handshake($urandom_range(0, 5), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_load();
        test_backpressure();
        test_ignored_start();
        test_wrap();
        test_reset_mid_load();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_operand_loader.md
Name: vector_operand_loader

Overview:
- Upstream feeder for the 5-lane vector ALU.
- On a start pulse, it fetches vector A (5 words) then vector B (5 words) from data memory. Memory is accessed through a single synchronous read port with 1-cycle latency.
- It holds the 10 operands plus the latched ALU op on registered outputs, then presents them with a valid/ready handshake.
- The consumer (vector ALU stage plus its writeback controller) asserts vec_ready when it takes the operands.

Parameters:
- DATA_W, 32, operand and memory data width.
- ADDR_W, 32, memory address width.
- OP_W, 3, width of the ALU operation code.
- STRIDE, 4, byte increment between consecutive vector elements.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request a new load; sampled only in IDLE.
- base_a  in  ADDR_W  byte address of element 0 of A; latched on start.
- base_b  in  ADDR_W  byte address of element 0 of B; latched on start.
- op  in  OP_W  ALU operation; latched on start.
- busy  out  1  high whenever state is not IDLE.
- mem_re  out  1  memory read enable.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  DATA_W  read data, valid in the cycle after mem_re.
- a_0..a_4  out  DATA_W each  A operands, registered.
- b_0..b_4  out  DATA_W each  B operands, registered.
- alu_op  out  OP_W  latched op, registered.
- vec_valid  out  1  operands complete and stable.
- vec_ready  in  1  consumer accepts the operands.

Behaviour:
- States and transitions:
  - IDLE: on start, go to FETCH.
  - FETCH: after 10 issues, go to LAST.
  - LAST: unconditionally go to VALID.
  - VALID: on vec_ready, go to IDLE.
- Reset (asynchronous, reset_n=0): state IDLE; issue and capture counters 0; every output 0 (busy, mem_re, mem_addr, a_*, b_*, alu_op, vec_valid). Reset mid-operation aborts immediately; no partial handshake survives.
- Start accept edge E0 (start=1 in IDLE, cycle 0): latch base_a, base_b, op; alu_op updates at E0.
- FETCH, cycles 1..10 — issue index i = 0..9:
  - mem_re=1.
  - mem_addr = base_a + STRIDE*i for i<5.
  - mem_addr = base_b + STRIDE*(i-5) for i>=5.
- Address arithmetic is modulo 2^ADDR_W (wrap-around allowed). Low address bits pass through unmodified; no alignment check.
- Capture: the data for index i is present in cycle i+2 and is written into a_i (i<5) or b_(i-5) at the end of that cycle.
- LAST (cycle 11): mem_re=0; capture index 9.
- VALID: vec_valid=1 from cycle 12, i.e. 12 cycles after the start cycle, held until vec_ready.
  - The vec_ready/vec_valid handshake completes on the edge where both are 1; vec_valid=0 and state IDLE in the next cycle.
  - vec_ready while not VALID is ignored.
- Stability: a_*, b_*, alu_op are constant throughout VALID and keep their values after the handshake until overwritten by the next load. While a load is in progress they may show a mix of old and new data.
- start while busy (including in the handshake cycle) is ignored; there is no queuing. A new start is accepted at the earliest in the first IDLE cycle after the handshake.
- base_a, base_b, op changes after E0 have no effect on the current load.
- mem_re=0 and mem_addr hold their last value in IDLE, LAST and VALID.
- No combinational path from any input to any output.

Decomposition:
- Shared package vec_pkg: N_ELEM=5, N_WORDS=10, the state enum {IDLE, FETCH, LAST, VALID}, and the default STRIDE.
- One natural sub-module: vector_operand_bank, the 10 x DATA_W register file with a write index and write enable, whose flattened outputs are a_0..b_4.
- FSM, counters and address generation stay in the top module.

Test Plan:
- Basic load:
  - Stimulus: base_a=0x100, base_b=0x200, op=3'd2; memory holds word(addr)=addr+0x1000.
  - Required: mem_addr sequence 0x100,0x104,..,0x110,0x200,..,0x210 in cycles 1..10.
  - Required: a_0=0x1100..a_4=0x1110, b_0=0x1200..b_4=0x1210, alu_op=2.
  - Required: vec_valid rises in cycle 12.
- Backpressure: hold vec_ready=0 for 20 cycles after vec_valid -> vec_valid stays 1, all operands unchanged, busy=1. Then vec_ready=1 for one cycle -> busy=0 and vec_valid=0 in the next cycle.
- Ignored start: pulse start with base_a=0x900 in cycle 5 of an active load, and again in the handshake cycle -> address sequence unaffected; no second load occurs.
- Wrap-around: base_a=0xFFFFFFF8 -> A addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8.
- Reset mid-load: assert reset_n=0 in cycle 6 -> mem_re, busy and all operands read 0 immediately. After release, a fresh start with base_a=0x40 completes normally with vec_valid in cycle 12.
- Back-to-back loads: handshake, then start in the first IDLE cycle with new bases -> second load completes with new data; operands from the first load are held until they are overwritten.
